// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract on operand
// magnitudes; signs are reapplied in a single FIX cycle. MTHI/MTLO are
// single-cycle writes taken only while idle.
module mul_div_unit #(
    parameter int bit_size = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [bit_size-1:0] src_a,
    input  logic [bit_size-1:0] src_b,
    output logic                busy,
    output logic                done,
    output logic                div_by_zero,
    output logic [bit_size-1:0] hi,
    output logic [bit_size-1:0] lo
);

    localparam int cnt_w = (bit_size > 1) ? $clog2(bit_size) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [cnt_w-1:0]    count;
    logic [bit_size-1:0] acc_hi;
    logic [bit_size-1:0] acc_lo;
    logic [bit_size-1:0] opnd;
    logic                is_mul;
    logic                dz;
    logic                neg_hi;
    logic                neg_lo;

    // Operand decode for an issue in IDLE
    logic                md_issue;
    logic                signed_op;
    logic                sign_a;
    logic                sign_b;
    logic [bit_size-1:0] mag_a;
    logic [bit_size-1:0] mag_b;
    logic                zero_div;

    // Per-iteration step and final sign-correction values
    logic [bit_size:0]     mul_sum;
    logic [bit_size:0]     div_shift;
    logic [bit_size:0]     div_diff;
    logic [bit_size-1:0]   step_hi;
    logic [bit_size-1:0]   step_lo;
    logic [2*bit_size-1:0] prod_fix;
    logic [bit_size-1:0]   fix_hi;
    logic [bit_size-1:0]   fix_lo;

    // Decode issue request and compute operand magnitudes
    always_comb begin
        md_issue  = start && !op[2];
        signed_op = !op[2] && !op[0];
        sign_a    = signed_op && src_a[bit_size-1];
        sign_b    = signed_op && src_b[bit_size-1];
        mag_a     = sign_a ? -src_a : src_a;
        mag_b     = sign_b ? -src_b : src_b;
        zero_div  = op[1] && (src_b == '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (md_issue) begin
                    state_next = zero_div ? FIX : CALC;
                end
            end
            CALC: begin
                if (count == '0) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        busy = (state == CALC) || (state == FIX);
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[bit_size-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (is_mul) begin
            step_hi = mul_sum[bit_size:1];
            step_lo = {mul_sum[0], acc_lo[bit_size-1:1]};
        end else if (!div_diff[bit_size]) begin
            step_hi = div_diff[bit_size-1:0];
            step_lo = {acc_lo[bit_size-2:0], 1'b1};
        end else begin
            step_hi = div_shift[bit_size-1:0];
            step_lo = {acc_lo[bit_size-2:0], 1'b0};
        end
    end

    // Sign correction: whole 2W product for multiply, quotient/remainder separately for divide
    always_comb begin
        prod_fix = {acc_hi, acc_lo};
        if (neg_lo) begin
            prod_fix = -prod_fix;
        end
        if (is_mul) begin
            fix_hi = prod_fix[2*bit_size-1:bit_size];
            fix_lo = prod_fix[bit_size-1:0];
        end else begin
            fix_hi = neg_hi ? -acc_hi : acc_hi;
            fix_lo = neg_lo ? -acc_lo : acc_lo;
        end
    end

    // Datapath, HI/LO and result flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            count       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            is_mul      <= 1'b0;
            dz          <= 1'b0;
            neg_hi      <= 1'b0;
            neg_lo      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= (state == FIX);
            div_by_zero <= (state == FIX) && dz;
            case (state)
                IDLE: begin
                    if (md_issue) begin
                        is_mul <= !op[1];
                        dz     <= zero_div;
                        count  <= cnt_w'(bit_size - 1);
                        acc_hi <= '0;
                        neg_lo <= sign_a ^ sign_b;
                        neg_hi <= op[1] ? sign_a : (sign_a ^ sign_b);
                        if (!op[1]) begin
                            acc_lo <= mag_b;
                            opnd   <= mag_a;
                        end else begin
                            acc_lo <= mag_a;
                            opnd   <= mag_b;
                        end
                    end else if (start && op == 3'b100) begin
                        hi <= src_a;
                    end else if (start && op == 3'b101) begin
                        lo <= src_a;
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count - 1'b1;
                end
                FIX: begin
                    if (!dz) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected results are queued when an op is
// issued and a monitor pops and compares them whenever done pulses.
module tb_mul_div_unit;

    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    mul_div_unit #(.bit_size(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .src_a(src_a),
        .src_b(src_b),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", hi, lo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hilo"}, {hi, lo}, {e.hi, e.lo});
                check({e.name, "_dz"}, 64'(div_by_zero), 64'(e.dz));
            end
        end
    end

    // Drive one request; called right after a negedge, returns #1 after the accepting edge
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic push(input string name, input logic [W-1:0] h, input logic [W-1:0] l, input logic z);
        exp_t e;
        e.name = name;
        e.hi   = h;
        e.lo   = l;
        e.dz   = z;
        sb.push_back(e);
    endtask

    // Wait (bounded) for done; lat counts negedges since the accepting edge
    task automatic wait_done(input string name, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, lat);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] h, input logic [W-1:0] l,
                          input logic z, input int exp_lat, input int exp_busy);
        int lat;
        int bc;
        push(name, h, l, z);
        issue(o, a, b);
        wait_done(name, lat, bc);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int bc;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'h0);
        check("reset_flags", {61'h0, busy, done, div_by_zero}, 64'h0);
        rst = 1'b1;
        @(negedge clk);

        // Multi-cycle ops: done on the (W+2)th negedge after acceptance, busy for W+1 cycles
        run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, W+2, W+1);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, W+2, W+1);
        run_op("mult_negxneg", OP_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0, 32'd14, 1'b0, W+2, W+1);
        run_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, W+2, W+1);
        run_op("divu_100by7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, W+2, W+1);
        run_op("div_min_by_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, W+2, W+1);
        run_op("div_7by_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, W+2, W+1);

        // MTHI/MTLO: single cycle, no busy
        issue(OP_MTHI, 32'h11, 32'h0);
        @(negedge clk);
        check("mthi", {31'h0, busy, hi}, {31'h0, 1'b0, 32'h11});
        issue(OP_MTLO, 32'h22, 32'h0);
        @(negedge clk);
        check("mtlo", {hi, lo}, {32'h11, 32'h22});

        // Divide by zero leaves HI/LO untouched
        run_op("divu_by_zero", OP_DIVU, 32'd100, 32'd0, 32'h11, 32'h22, 1'b1, 2, 1);

        // Start-while-busy MTLO is ignored
        push("mult_6x7_ignore", 32'h0, 32'd42, 1'b0);
        issue(OP_MULT, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        issue(OP_MTLO, 32'hAA, 32'h0);
        wait_done("mult_6x7_ignore", lat, bc);

        // Back-to-back: new start in the cycle done is high
        run_op("divu_b2b", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, W+2, W+1);

        // op=11x is a no-op
        issue(3'b110, 32'h1234, 32'h5678);
        @(negedge clk);
        check("noop110", {31'h0, busy, hi, lo}, {31'h0, 1'b0, 32'd2, 32'd14});
        issue(3'b111, 32'h1234, 32'h5678);
        @(negedge clk);
        check("noop111", {31'h0, busy, hi, lo}, {31'h0, 1'b0, 32'd2, 32'd14});

        // Reset mid-operation discards the op
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_hilo", {hi, lo}, 64'h0);
        check("abort_flags", {61'h0, busy, done, div_by_zero}, 64'h0);
        repeat (W + 4) @(negedge clk);
        issue(OP_MTHI, 32'h5, 32'h0);
        @(negedge clk);
        check("mthi_after_abort", {hi, lo}, {32'h5, 32'h0});

        repeat (W + 4) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
